// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state encoding
// and the lowest-set-bit priority encoder plus its one-hot to binary converter.
package rr_arb_pkg;

  localparam int MAX_N   = 64;
  localparam int MAX_IDW = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  // Isolates the lowest set bit; zero in gives zero out.
  function automatic logic [MAX_N-1:0] onehot_lsb(input logic [MAX_N-1:0] vec);
    return vec & (~vec + MAX_N'(1));
  endfunction

  function automatic logic [MAX_IDW-1:0] onehot2bin(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] id;
    id = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) id = id | MAX_IDW'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_mask_pe.sv
// Combinational rotating-priority winner search: first request strictly above
// ptr, otherwise wrap to the lowest request overall.
module rr_mask_pe
  import rr_arb_pkg::*;
#(
  parameter int N   = 64,
  parameter int IDW = 6
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   winner_onehot,
  output logic [IDW-1:0] winner_id,
  output logic           any_req
);

  logic [MAX_N-1:0]   req_ext;
  logic [MAX_N-1:0]   above;
  logic [MAX_N-1:0]   masked;
  logic [MAX_N-1:0]   pick;
  logic [MAX_IDW-1:0] id_ext;

  // Bits above N-1 of req_ext are always zero, so the extended mask is harmless.
  always_comb begin
    req_ext = MAX_N'(req);
    above   = ~((MAX_N'(2) << ptr) - MAX_N'(1));
    masked  = req_ext & above;
    pick    = (masked != '0) ? onehot_lsb(masked) : onehot_lsb(req_ext);
  end

  assign id_ext        = onehot2bin(pick);
  assign winner_onehot = pick[N-1:0];
  assign winner_id     = id_ext[IDW-1:0];
  assign any_req       = |req;

endmodule

// File: rtl/rr_arb64.sv
// Round-robin arbiter with registered one-hot grant, hold timer and a
// one-cycle turnaround gap after every grant.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; any request is granted at the next edge
// GRANTED | grant held until release, withdrawal or hold-timer expiry
// RECOVER | one-cycle bus turnaround with grant low, then back to IDLE
module rr_arb64
  import rr_arb_pkg::*;
#(
  parameter int N        = 64,
  parameter int IDW      = 6,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           grant_release,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout,
  output logic           busy
);

  localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  // With the timer disabled the counter simply parks at all-ones.
  localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HCW{1'b1}} : HCW'(MAX_HOLD);

  arb_state_e     state, state_nx;
  logic [IDW-1:0] ptr, ptr_nx;
  logic [IDW-1:0] id_nx;
  logic [N-1:0]   grant_nx;
  logic [HCW-1:0] hold_cnt, hold_nx;
  logic           timeout_nx;

  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_id;
  logic           any_req;
  logic           owner_req;
  logic           hold_expired;
  logic           end_grant;

  rr_mask_pe #(
    .N   (N),
    .IDW (IDW)
  ) u_pe (
    .req           (req),
    .ptr           (ptr),
    .winner_onehot (win_oh),
    .winner_id     (win_id),
    .any_req       (any_req)
  );

  assign owner_req    = req[grant_id];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
  assign end_grant    = grant_release || !owner_req || hold_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= IDW'(N - 1);
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      grant_id <= id_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      timeout  <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    id_nx      = grant_id;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = GRANTED;
          grant_nx = win_oh;
          id_nx    = win_id;
          ptr_nx   = win_id;
          hold_nx  = HCW'(1);
        end
      end
      GRANTED: begin
        if (end_grant) begin
          state_nx   = RECOVER;
          grant_nx   = '0;
          hold_nx    = '0;
          // Release or withdrawal in the expiry cycle takes precedence.
          timeout_nx = hold_expired && !grant_release && owner_req;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nx = hold_cnt + HCW'(1);
        end
      end
      RECOVER: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_comb begin
    grant_valid = |grant;
    busy        = (state == GRANTED) || (state == RECOVER);
  end

endmodule

// File: tb/tb_rr_arb64.sv
// Scenario bench for rr_arb64: expected grant ids are queued as requests are
// driven and a negedge monitor pops them as each new grant appears.
module tb_rr_arb64;

  localparam int N        = 64;
  localparam int IDW      = 6;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           grant_release = 1'b0;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int timeout_seen = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;
  bit mon_en = 1'b0;

  rr_arb64 #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .grant_release (grant_release),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((grant_valid !== (|grant)) || ((grant & (grant - N'(1))) !== '0)) begin
        failures++;
        $display("FAIL invariant grant=%h grant_valid=%b", grant, grant_valid);
      end
      if (timeout === 1'b1) timeout_seen++;
      if (grant_valid === 1'b1 && prev_valid !== 1'b1) begin
        int e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant got id=%0d expected none", grant_id);
        end else begin
          e = exp_q.pop_front();
          if (grant_id !== IDW'(e) || grant !== (N'(1) << e)) begin
            failures++;
            $display("FAIL grant_order got id=%0d grant=%h expected id=%0d", grant_id, grant, e);
          end
        end
      end
    end
    prev_valid = grant_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    grant_release = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, output bit ok);
    int n = 0;
    while (grant_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    ok = (grant_valid === 1'b1);
    if (!ok) begin
      failures++;
      $display("FAIL %s_wait no grant after %0d cycles expected grant", tag, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== '0 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values grant=%h valid=%b id=%0d timeout=%b busy=%b expected all zero",
               grant, grant_valid, grant_id, timeout, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    grant_release = 1'b1;
    @(negedge clk);
    grant_release = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL release_in_idle valid=%b busy=%b timeout=%b expected 0 0 0", grant_valid, busy, timeout);
    end
  endtask

  task automatic test_single();
    exp_q.push_back(0);
    exp_q.push_back(0);
    req = 64'h1;
    @(negedge clk);
    checks++;
    if (grant !== 64'h1 || grant_id !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_first grant=%h id=%0d busy=%b expected grant=1 id=0 busy=1", grant, grant_id, busy);
    end
    grant_release = 1'b1;
    @(negedge clk);
    grant_release = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_recover valid=%b busy=%b expected 0 1", grant_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_gap2 valid=%b busy=%b expected 0 0", grant_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (grant !== 64'h1) begin
      failures++;
      $display("FAIL single_regrant grant=%h expected 1", grant);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_withdraw valid=%b timeout=%b busy=%b expected 0 0 1", grant_valid, timeout, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int order[4] = '{0, 5, 63, 0};
    int idle;
    bit ok;
    do_reset();
    foreach (order[k]) exp_q.push_back(order[k]);
    req = (64'h1) | (64'h1 << 5) | (64'h1 << 63);
    for (int k = 0; k < 4; k++) begin
      wait_grant("rot", ok);
      if (!ok) break;
      checks++;
      if (grant_id !== IDW'(order[k])) begin
        failures++;
        $display("FAIL rot_id step=%0d got=%0d expected=%0d", k, grant_id, order[k]);
      end
      grant_release = 1'b1;
      @(negedge clk);
      grant_release = 1'b0;
      if (k == 3) req = '0;
      idle = 0;
      while (grant_valid !== 1'b1 && idle < 10) begin
        idle++;
        @(negedge clk);
      end
      if (k < 3) begin
        checks++;
        if (idle != 2) begin
          failures++;
          $display("FAIL rot_gap step=%0d got=%0d idle cycles expected=2", k, idle);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int held;
    int t0;
    bit ok;
    do_reset();
    exp_q.push_back(7);
    exp_q.push_back(3);
    exp_q.push_back(7);
    t0 = timeout_seen;
    req = 64'h1 << 7;
    wait_grant("to", ok);
    held = 0;
    while (grant_valid === 1'b1 && held < 40) begin
      held++;
      if (held == 1) req[3] = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (held != MAX_HOLD) begin
      failures++;
      $display("FAIL to_hold got=%0d cycles expected=%0d", held, MAX_HOLD);
    end
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_pulse timeout=%b expected 1", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse_width timeout=%b valid=%b expected 0 0", timeout, grant_valid);
    end
    wait_grant("to_next", ok);
    checks++;
    if (grant_id !== IDW'(3)) begin
      failures++;
      $display("FAIL to_next got=%0d expected=3", grant_id);
    end
    grant_release = 1'b1;
    @(negedge clk);
    grant_release = 1'b0;
    wait_grant("to_back", ok);
    checks++;
    if (grant_id !== IDW'(7)) begin
      failures++;
      $display("FAIL to_back got=%0d expected=7", grant_id);
    end
    req = '0;
    grant_release = 1'b1;
    @(negedge clk);
    grant_release = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (timeout_seen - t0 != 1) begin
      failures++;
      $display("FAIL to_count got=%0d pulses expected=1", timeout_seen - t0);
    end
  endtask

  task automatic test_withdraw();
    bit ok;
    exp_q.push_back(10);
    req = 64'h1 << 10;
    wait_grant("wd", ok);
    req = '0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wd_recover valid=%b timeout=%b busy=%b expected 0 0 1", grant_valid, timeout, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_id !== IDW'(10)) begin
      failures++;
      $display("FAIL wd_idle busy=%b id=%0d expected busy=0 id=10", busy, grant_id);
    end
  endtask

  task automatic test_release_at_timeout();
    bit ok;
    exp_q.push_back(20);
    req = 64'h1 << 20;
    wait_grant("rt", ok);
    repeat (MAX_HOLD - 1) @(negedge clk);
    checks++;
    if (grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL rt_held valid=%b expected 1", grant_valid);
    end
    grant_release = 1'b1;
    @(negedge clk);
    grant_release = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rt_release valid=%b timeout=%b busy=%b expected 0 0 1", grant_valid, timeout, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL rt_no_timeout timeout=%b expected 0", timeout);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    exp_q.push_back(9);
    req = 64'h1 << 9;
    wait_grant("ar", ok);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || grant_valid !== 1'b0 || busy !== 1'b0 || grant_id !== '0) begin
      failures++;
      $display("FAIL ar_immediate grant=%h valid=%b busy=%b id=%0d expected all zero",
               grant, grant_valid, busy, grant_id);
    end
    req = (64'h1 << 2) | (64'h1 << 40);
    exp_q.push_back(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("ar_first", ok);
    checks++;
    if (grant_id !== IDW'(2)) begin
      failures++;
      $display("FAIL ar_first got=%0d expected=2", grant_id);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_withdraw();
    test_release_at_timeout();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
